// File: rtl/div_unit_if.sv
// Request/write-back bundle between the core and the divider.
// master: core drives start/op/operands/rd_addr; slave: divider drives busy/done/wb_*.
interface div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr,
    input  busy, done, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr,
    output busy, done, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider, one quotient bit per clock.
// Ports: clk, rst (async, active-high), bus (div_unit_if.slave: start/op/rs1_data/
// rs2_data/rd_addr in; busy/done/wb_we/wb_addr/wb_data out).
// Option: DIV_FAST_PATH_EN finishes divide-by-zero and signed overflow in one edge.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [5:0]         cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic               q_neg;
  logic               r_neg;
  logic               spec_q;
  logic               div0_q;

  logic               sgn;
  logic               div0;
  logic               ovf;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quot_nx;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;
  logic [WIDTH-1:0]   res;
  logic               accept;

  function automatic logic [WIDTH-1:0] spec_val(
    input logic [1:0]       o,
    input logic [WIDTH-1:0] a,
    input logic             z
  );
    if (z) spec_val = o[1] ? a : '1;
    else   spec_val = o[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  always_comb begin
    sgn   = ~bus.op[0];
    div0  = (bus.rs2_data == '0);
    ovf   = sgn
         && (bus.rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
         && (bus.rs2_data == '1);
    a_mag = (sgn && bus.rs1_data[WIDTH-1]) ? -bus.rs1_data
                                           : bus.rs1_data;
    b_mag = (sgn && bus.rs2_data[WIDTH-1]) ? -bus.rs2_data
                                           : bus.rs2_data;
  end

  // 33-bit trial keeps the borrow; rem < dvs so the difference fits 32 bits.
  always_comb begin
    trial   = {rem, quot[WIDTH-1]};
    diff    = trial - {1'b0, dvs};
    ge      = ~diff[WIDTH];
    rem_nx  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_nx = {quot[WIDTH-2:0], ge};
    q_fin   = q_neg ? -quot_nx : quot_nx;
    r_fin   = r_neg ? -rem_nx : rem_nx;
    res     = spec_q ? spec_val(op_q, dvd_q, div0_q)
                     : (op_q[1] ? r_fin : q_fin);
  end

  assign accept      = bus.start && (state != CALC);
  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.wb_we   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      dvd_q       <= '0;
      dvs         <= '0;
      rem         <= '0;
      quot        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      spec_q      <= 1'b0;
      div0_q      <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else if (accept) begin
      op_q        <= bus.op;
      dvd_q       <= bus.rs1_data;
      dvs         <= b_mag;
      rem         <= '0;
      quot        <= a_mag;
      q_neg       <= sgn && (bus.rs1_data[WIDTH-1] ^ bus.rs2_data[WIDTH-1]);
      r_neg       <= sgn && bus.rs1_data[WIDTH-1];
      spec_q      <= div0 || ovf;
      div0_q      <= div0;
      cnt         <= '0;
      bus.wb_addr <= bus.rd_addr;
`ifdef DIV_FAST_PATH_EN
      if (div0 || ovf) begin
        state       <= DONE;
        bus.wb_data <= spec_val(bus.op, bus.rs1_data, div0);
      end else begin
        state <= CALC;
      end
`else
      state <= CALC;
`endif
    end else begin
      unique case (state)
        CALC: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) begin
            state       <= DONE;
            bus.wb_data <= res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits between the register file read ports and its write port. Operands come from `rd1`/`rd2`. The result goes back through `we3`/`a3`/`wd3` via a one-cycle write-back strobe. It uses a radix-2 restoring algorithm, one quotient bit per clock. The core stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled on a rising edge only when `busy` is low.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with `start`.
- `rs1_data`  in  32  dividend (register file `rd1`); captured with `start`.
- `rs2_data`  in  32  divisor (register file `rd2`); captured with `start`.
- `rd_addr`  in  5  destination register; captured with `start`.
- `busy`  out  1  high while iterating; new `start` is ignored.
- `done`  out  1  one-cycle completion pulse.
- `wb_we`  out  1  equals `done`; drives register file `we3`.
- `wb_addr`  out  5  latched `rd_addr`; drives `a3`.
- `wb_data`  out  32  result; drives `wd3`; holds its value until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start`=1, normal operands -> CALC.
  - Capture `op` and `rd_addr`.
  - Capture |dividend| and |divisor|. The magnitude is the absolute value for signed ops and the raw value for unsigned ops.
  - Record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Clear the 6-bit counter.
- CALC: each edge shifts {rem, quot} left by 1.
  - If the trial remainder is >= the divisor: subtract the divisor and set the quotient LSB.
  - Counter increments.
  - After the 32nd iteration -> DONE. `wb_data` loads the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
- DONE: `done`=`wb_we`=1 for exactly one cycle. Next edge -> IDLE, or -> CALC if `start`=1 in this cycle (back-to-back accepted).
- Special cases (RISC-V spec values, independent of configuration):
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0x00000000.
- `busy` = (state == CALC). `done` is low in IDLE and CALC.
- Subtraction is 33-bit so the carry is not lost. Negation is two's complement at 32 bits. |0x80000000| = 0x80000000 (unsigned interpretation).
- `rd_addr`=0 completes normally. The register file discards the write.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `wb_we`=0, `wb_addr`=0, `wb_data`=0; counter 0.
- Normal latency: `start` sampled at edge E -> `busy` high after E -> `done` high in the cycle after edge E+32 (33 edges).
- `busy` drops the same edge `done` rises.
- `start` while `busy`=1 is ignored. Its operands are not captured and no `done` is generated for it.
- `rst` asserted mid-CALC returns to IDLE immediately. No `done` pulse is generated and the partial result is discarded.
- Operand inputs may change freely after the capturing edge.

## Configuration
- `DIV_FAST_PATH_EN` defined:
  - Divide-by-zero and signed-overflow requests go IDLE -> DONE on the capturing edge.
  - `done` is high in the next cycle (1-edge latency).
  - `busy` stays low.
- Not defined:
  - These cases take the full CALC path with 33-edge latency.
  - The final result mux substitutes the spec values.
  - Results are identical in both configurations; only latency differs.

## Test plan
- DIVU 100 / 7 -> `done` 33 edges after start; `wb_data`=14. REMU of the same operands -> 2. `wb_addr` equals the captured `rd_addr`.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD (−3). REM of the same operands -> 0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
- Divide 0x12345678 by 0:
  - DIV -> 0xFFFFFFFF; REMU -> 0x12345678.
  - Latency is 1 edge with `DIV_FAST_PATH_EN` and 33 edges without it.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Second `start` with different operands at edge E+5 is ignored: exactly one `done`, carrying the first result. A `start` asserted in the DONE cycle launches a new op with no gap.
- `rst` pulse at edge E+10 -> `busy`=0 asynchronously; no `done` ever follows. A subsequent DIVU 9 / 3 returns 3.
